// File: rtl/aes_round_controller.sv
// AES-128 round controller: sequences an external round engine with on-the-fly key expansion; 42-cycle accept-to-response latency.
// Backpressure: one block in flight; req_ready_out is low until the response handshakes, and the response holds while resp_ready_in is low.
module aes_round_controller (
    input  logic         clk_in,
    input  logic         rst_n_in,
    input  logic         req_valid_in,
    output logic         req_ready_out,
    input  logic [127:0] req_data_in,
    input  logic [127:0] req_key_in,
    output logic         resp_valid_out,
    input  logic         resp_ready_in,
    output logic [127:0] resp_data_out,
    output logic         eng_init_out,
    output logic [127:0] eng_data_out,
    output logic [3:0]   eng_round_out,
    output logic [127:0] eng_key_out,
    input  logic         eng_next_round_in,
    input  logic [127:0] eng_data_in,
    input  logic         eng_valid_in
);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        ROUND0,
        RUN,
        RESP
    } state_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    state_t         state_q;
    state_t         state_nx;
    logic [127:0]   data_q;
    logic [127:0]   key_q;
    logic [127:0]   resp_q;
    logic [3:0]     round_q;
    logic           skip_q;

    logic           accept;
    logic           key_step;
    logic           skip_set;
    logic           skip_clr;
    logic           capture;
    logic           release_blk;

    logic [127:0]   key_nx;
    logic [31:0]    rot_word;
    logic [31:0]    sub_word;
    logic [31:0]    temp_word;
    logic [31:0]    nw0;
    logic [31:0]    nw1;
    logic [31:0]    nw2;
    logic [31:0]    nw3;

    // Engine byte 4*r+c is FIPS byte 4*c+r; the mapping is its own inverse.
    function automatic logic [127:0] transpose(input logic [127:0] src);
        logic [127:0] dst;
        dst = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                dst[127 - 8*(4*r + c) -: 8] = src[127 - 8*(4*c + r) -: 8];
            end
        end
        return dst;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] val;
        case (idx)
            4'd1:    val = 8'h01;
            4'd2:    val = 8'h02;
            4'd3:    val = 8'h04;
            4'd4:    val = 8'h08;
            4'd5:    val = 8'h10;
            4'd6:    val = 8'h20;
            4'd7:    val = 8'h40;
            4'd8:    val = 8'h80;
            4'd9:    val = 8'h1b;
            4'd10:   val = 8'h36;
            default: val = 8'h00;
        endcase
        return val;
    endfunction

    // Next round key K(round+1) from the current key; round_q is 0 in ROUND0.
    always_comb begin
        rot_word  = {key_q[23:0], key_q[31:24]};
        sub_word  = {SBOX[rot_word[31:24]], SBOX[rot_word[23:16]],
                     SBOX[rot_word[15:8]],  SBOX[rot_word[7:0]]};
        temp_word = sub_word ^ {rcon(round_q + 4'd1), 24'h000000};
        nw0       = key_q[127:96] ^ temp_word;
        nw1       = key_q[95:64]  ^ nw0;
        nw2       = key_q[63:32]  ^ nw1;
        nw3       = key_q[31:0]   ^ nw2;
        key_nx    = {nw0, nw1, nw2, nw3};
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state_q;
        accept      = 1'b0;
        key_step    = 1'b0;
        skip_set    = 1'b0;
        skip_clr    = 1'b0;
        capture     = 1'b0;
        release_blk = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_in) begin
                    accept   = 1'b1;
                    state_nx = INIT;
                end
            end
            INIT: begin
                state_nx = ROUND0;
            end
            ROUND0: begin
                key_step = 1'b1;
                skip_set = 1'b1;
                state_nx = RUN;
            end
            RUN: begin
                // The first pulse belongs to the engine's round-0 AddRoundKey.
                if (eng_next_round_in && (round_q < 4'd10)) begin
                    if (skip_q) begin
                        skip_clr = 1'b1;
                    end else begin
                        key_step = 1'b1;
                    end
                end
                if (eng_valid_in && (round_q == 4'd10)) begin
                    capture  = 1'b1;
                    state_nx = RESP;
                end
            end
            RESP: begin
                if (resp_ready_in) begin
                    release_blk = 1'b1;
                    state_nx    = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            data_q  <= '0;
            key_q   <= '0;
            resp_q  <= '0;
            round_q <= '0;
            skip_q  <= 1'b0;
        end else begin
            if (accept) begin
                data_q  <= req_data_in;
                key_q   <= req_key_in;
                round_q <= '0;
                skip_q  <= 1'b0;
            end
            if (key_step) begin
                key_q   <= key_nx;
                round_q <= round_q + 4'd1;
            end
            if (skip_set) begin
                skip_q <= 1'b1;
            end
            if (skip_clr) begin
                skip_q <= 1'b0;
            end
            if (capture) begin
                resp_q <= transpose(eng_data_in);
            end
            if (release_blk) begin
                key_q   <= '0;
                round_q <= '0;
                skip_q  <= 1'b0;
            end
        end
    end

    assign req_ready_out  = (state_q == IDLE);
    assign resp_valid_out = (state_q == RESP);
    assign resp_data_out  = resp_q;
    assign eng_init_out   = (state_q == INIT);
    assign eng_data_out   = transpose(data_q);
    assign eng_key_out    = transpose(key_q);
    assign eng_round_out  = round_q;

endmodule

// File: tb/tb_aes_round_controller.sv
// Directed bench for aes_round_controller with a behavioural round engine (AddRoundKey pulse, 4-cycle rounds, 3-cycle final round).
module tb_aes_round_controller;

    logic         clk_in;
    logic         rst_n_in;
    logic         req_valid_in;
    logic         req_ready_out;
    logic [127:0] req_data_in;
    logic [127:0] req_key_in;
    logic         resp_valid_out;
    logic         resp_ready_in;
    logic [127:0] resp_data_out;
    logic         eng_init_out;
    logic [127:0] eng_data_out;
    logic [3:0]   eng_round_out;
    logic [127:0] eng_key_out;
    logic         eng_next_round_in;
    logic [127:0] eng_data_in;
    logic         eng_valid_in;

    logic         eng_nr_m;
    logic         eng_valid_m;
    logic [127:0] eng_data_m;
    logic         spur_valid;
    logic [127:0] spur_data;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]   sb [0:255];
    logic [3:0]   trace_round [0:63];
    logic         trace_init  [0:63];
    logic [127:0] key10_seen;

    localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K10_A = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

    assign eng_next_round_in = eng_nr_m;
    assign eng_valid_in      = eng_valid_m | spur_valid;
    assign eng_data_in       = spur_valid ? spur_data : eng_data_m;

    aes_round_controller dut (
        .clk_in            (clk_in),
        .rst_n_in          (rst_n_in),
        .req_valid_in      (req_valid_in),
        .req_ready_out     (req_ready_out),
        .req_data_in       (req_data_in),
        .req_key_in        (req_key_in),
        .resp_valid_out    (resp_valid_out),
        .resp_ready_in     (resp_ready_in),
        .resp_data_out     (resp_data_out),
        .eng_init_out      (eng_init_out),
        .eng_data_out      (eng_data_out),
        .eng_round_out     (eng_round_out),
        .eng_key_out       (eng_key_out),
        .eng_next_round_in (eng_next_round_in),
        .eng_data_in       (eng_data_in),
        .eng_valid_in      (eng_valid_in)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] tr(input logic [127:0] src);
        logic [127:0] dst;
        dst = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                dst[127 - 8*(4*r + c) -: 8] = src[127 - 8*(4*c + r) -: 8];
        return dst;
    endfunction

    // One FIPS-order cipher round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
    function automatic logic [127:0] aes_rnd(input logic [127:0] s, input logic [127:0] k, input bit last);
        logic [7:0]   a [0:15];
        logic [7:0]   b [0:15];
        logic [7:0]   x0, x1, x2, x3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) a[i] = sb[s[127 - 8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                b[4*c + r] = a[4*((c + r) % 4) + r];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                x0 = b[4*c]; x1 = b[4*c+1]; x2 = b[4*c+2]; x3 = b[4*c+3];
                b[4*c]   = xt(x0) ^ xt(x1) ^ x1 ^ x2 ^ x3;
                b[4*c+1] = x0 ^ xt(x1) ^ xt(x2) ^ x2 ^ x3;
                b[4*c+2] = x0 ^ x1 ^ xt(x2) ^ xt(x3) ^ x3;
                b[4*c+3] = xt(x0) ^ x0 ^ x1 ^ x2 ^ xt(x3);
            end
        end
        o = '0;
        for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = b[i];
        return o ^ k;
    endfunction

    // Round engine: ARK pulse 2 cycles after init, round r pulse at 2+4r, done pulse at 41.
    initial begin
        logic [127:0] st;
        int  et;
        bit  active;
        eng_nr_m    = 1'b0;
        eng_valid_m = 1'b0;
        eng_data_m  = '0;
        st = '0;
        et = 0;
        active = 1'b0;
        forever begin
            @(negedge clk_in);
            eng_nr_m    = 1'b0;
            eng_valid_m = 1'b0;
            if (!rst_n_in) begin
                active = 1'b0;
            end else if (active) begin
                et++;
                if (et == 2) begin
                    eng_nr_m = 1'b1;
                end else if (et >= 6 && et <= 38 && ((et - 2) % 4) == 0) begin
                    st = aes_rnd(st, tr(eng_key_out), 1'b0);
                    eng_nr_m = 1'b1;
                end else if (et == 41) begin
                    st = aes_rnd(st, tr(eng_key_out), 1'b1);
                    eng_data_m  = tr(st);
                    eng_valid_m = 1'b1;
                    active = 1'b0;
                end
            end else if (eng_init_out) begin
                st = tr(eng_data_out) ^ tr(eng_key_out);
                et = 0;
                active = 1'b1;
            end
        end
    end

    // Called at a negedge; returns just after the accepting edge with req_valid_in dropped.
    task automatic send_req(input logic [127:0] key, input logic [127:0] pt);
        bit ok;
        ok = 1'b0;
        req_key_in   = key;
        req_data_in  = pt;
        req_valid_in = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (req_ready_out) ok = 1'b1;
            else @(negedge clk_in);
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL accept: req_ready_out never %0d, required 1", req_ready_out);
        end
        @(posedge clk_in);
        #1 req_valid_in = 1'b0;
    endtask

    // Samples each negedge after the accept edge; lat = -1 when no response appears.
    task automatic wait_resp(output int lat, output logic [127:0] ct);
        lat = -1;
        ct  = '0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk_in);
            trace_round[i] = eng_round_out;
            trace_init[i]  = eng_init_out;
            if (eng_round_out == 4'd10) key10_seen = eng_key_out;
            if (resp_valid_out) begin
                lat = i;
                ct  = resp_data_out;
                break;
            end
        end
    endtask

    task automatic test_reset();
        n_cmp++; if (req_ready_out !== 1'b1) begin n_err++; $display("FAIL rst_req_ready: got %b want 1", req_ready_out); end
        n_cmp++; if (resp_valid_out !== 1'b0) begin n_err++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid_out); end
        n_cmp++; if (eng_init_out !== 1'b0) begin n_err++; $display("FAIL rst_eng_init: got %b want 0", eng_init_out); end
        n_cmp++; if (eng_round_out !== 4'd0) begin n_err++; $display("FAIL rst_eng_round: got %0d want 0", eng_round_out); end
        n_cmp++; if (eng_key_out !== 128'h0) begin n_err++; $display("FAIL rst_eng_key: got %h want 0", eng_key_out); end
        n_cmp++; if (eng_data_out !== 128'h0) begin n_err++; $display("FAIL rst_eng_data: got %h want 0", eng_data_out); end
        n_cmp++; if (resp_data_out !== 128'h0) begin n_err++; $display("FAIL rst_resp_data: got %h want 0", resp_data_out); end
    endtask

    task automatic test_fips_c1();
        int lat;
        logic [127:0] ct;
        send_req(KEY_A, PT_A);
        wait_resp(lat, ct);
        n_cmp++; if (lat != 42) begin n_err++; $display("FAIL c1_latency: got %0d want 42", lat); end
        n_cmp++; if (ct !== CT_A) begin n_err++; $display("FAIL c1_ciphertext: got %h want %h", ct, CT_A); end
        n_cmp++; if (req_ready_out !== 1'b0) begin n_err++; $display("FAIL c1_ready_in_resp: got %b want 0", req_ready_out); end
        @(negedge clk_in);
        n_cmp++; if (resp_valid_out !== 1'b0) begin n_err++; $display("FAIL c1_resp_drop: got %b want 0", resp_valid_out); end
        n_cmp++; if (req_ready_out !== 1'b1) begin n_err++; $display("FAIL c1_idle_ready: got %b want 1", req_ready_out); end
    endtask

    task automatic test_round_trace();
        int lat;
        logic [127:0] ct;
        send_req(KEY_A, PT_A);
        wait_resp(lat, ct);
        n_cmp++; if (lat != 42) begin n_err++; $display("FAIL trace_latency: got %0d want 42", lat); end
        if (lat == 42) begin
            n_cmp++; if (trace_round[0] !== 4'd0 || trace_init[0] !== 1'b1) begin n_err++; $display("FAIL trace_init_cycle: got round %0d init %b want 0/1", trace_round[0], trace_init[0]); end
            n_cmp++; if (trace_round[1] !== 4'd0 || trace_init[1] !== 1'b0) begin n_err++; $display("FAIL trace_round0_cycle: got round %0d init %b want 0/0", trace_round[1], trace_init[1]); end
            n_cmp++; if (trace_round[6] !== 4'd1) begin n_err++; $display("FAIL trace_ark_pulse_skipped: got %0d want 1", trace_round[6]); end
            for (int r = 1; r <= 9; r++) begin
                n_cmp++;
                if (trace_round[3 + 4*r] !== 4'(r + 1)) begin
                    n_err++;
                    $display("FAIL trace_round_%0d: got %0d want %0d", r + 1, trace_round[3 + 4*r], r + 1);
                end
            end
            n_cmp++; if (tr(key10_seen) !== K10_A) begin n_err++; $display("FAIL trace_k10: got %h want %h", tr(key10_seen), K10_A); end
        end
        @(negedge clk_in);
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        logic [127:0] ct;
        resp_ready_in = 1'b0;
        send_req(KEY_B, PT_B);
        wait_resp(lat, ct);
        n_cmp++; if (ct !== CT_B) begin n_err++; $display("FAIL bp_ciphertext: got %h want %h", ct, CT_B); end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            if (resp_valid_out !== 1'b1 || resp_data_out !== CT_B || req_ready_out !== 1'b0) bad++;
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL bp_hold: %0d unstable cycles, want 0 (valid %b data %h ready %b)", bad, resp_valid_out, resp_data_out, req_ready_out); end
        resp_ready_in = 1'b1;
        @(negedge clk_in);
        n_cmp++; if (resp_valid_out !== 1'b0) begin n_err++; $display("FAIL bp_release_valid: got %b want 0", resp_valid_out); end
        n_cmp++; if (req_ready_out !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b want 1", req_ready_out); end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [127:0] ct;
        req_key_in   = KEY_A;
        req_data_in  = PT_A;
        req_valid_in = 1'b1;
        n_cmp++; if (req_ready_out !== 1'b1) begin n_err++; $display("FAIL b2b_first_ready: got %b want 1", req_ready_out); end
        @(posedge clk_in);
        wait_resp(lat, ct);
        n_cmp++; if (lat != 42 || ct !== CT_A) begin n_err++; $display("FAIL b2b_first: got lat %0d ct %h want 42 %h", lat, ct, CT_A); end
        n_cmp++; if (req_ready_out !== 1'b0) begin n_err++; $display("FAIL b2b_no_same_cycle: got %b want 0", req_ready_out); end
        req_key_in  = KEY_B;
        req_data_in = PT_B;
        @(negedge clk_in);
        n_cmp++; if (req_ready_out !== 1'b1) begin n_err++; $display("FAIL b2b_idle_reentry: got %b want 1", req_ready_out); end
        @(posedge clk_in);
        #1 req_valid_in = 1'b0;
        wait_resp(lat, ct);
        n_cmp++; if (lat != 42 || ct !== CT_B) begin n_err++; $display("FAIL b2b_second: got lat %0d ct %h want 42 %h", lat, ct, CT_B); end
        @(negedge clk_in);
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen;
        bit hit;
        logic [127:0] ct;
        send_req(KEY_A, PT_A);
        hit = 1'b0;
        for (int i = 0; i < 64 && !hit; i++) begin
            @(negedge clk_in);
            if (eng_round_out == 4'd5) hit = 1'b1;
        end
        n_cmp++; if (!hit) begin n_err++; $display("FAIL mid_reach_round5: got %0d want 5", eng_round_out); end
        #2 rst_n_in = 1'b0;
        #1;
        n_cmp++; if (eng_round_out !== 4'd0 || eng_key_out !== 128'h0) begin n_err++; $display("FAIL mid_async_round_key: got %0d %h want 0 0", eng_round_out, eng_key_out); end
        n_cmp++; if (eng_data_out !== 128'h0 || resp_data_out !== 128'h0) begin n_err++; $display("FAIL mid_async_data: got %h %h want 0 0", eng_data_out, resp_data_out); end
        n_cmp++; if (resp_valid_out !== 1'b0 || eng_init_out !== 1'b0) begin n_err++; $display("FAIL mid_async_flags: got %b %b want 0 0", resp_valid_out, eng_init_out); end
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_in);
            if (resp_valid_out) seen++;
        end
        n_cmp++; if (seen != 0) begin n_err++; $display("FAIL mid_no_response: got %0d cycles valid want 0", seen); end
        send_req(KEY_B, PT_B);
        wait_resp(lat, ct);
        n_cmp++; if (lat != 42 || ct !== CT_B) begin n_err++; $display("FAIL mid_after_reset: got lat %0d ct %h want 42 %h", lat, ct, CT_B); end
        @(negedge clk_in);
    endtask

    task automatic test_spurious();
        int lat;
        int seen;
        bit fired;
        logic [127:0] ct;
        spur_data  = 128'hdeadbeef_cafef00d_01234567_89abcdef;
        spur_valid = 1'b1;
        @(negedge clk_in);
        spur_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            if (resp_valid_out) seen++;
        end
        n_cmp++; if (seen != 0 || req_ready_out !== 1'b1) begin n_err++; $display("FAIL spur_idle: got valid cycles %0d ready %b want 0 1", seen, req_ready_out); end
        send_req(KEY_A, PT_A);
        lat = -1;
        ct = '0;
        fired = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk_in);
            spur_valid = 1'b0;
            if (resp_valid_out) begin
                lat = i;
                ct = resp_data_out;
                break;
            end
            if (!fired && eng_round_out == 4'd3) begin
                spur_valid = 1'b1;
                fired = 1'b1;
            end
        end
        spur_valid = 1'b0;
        n_cmp++; if (lat != 42) begin n_err++; $display("FAIL spur_round3_latency: got %0d want 42", lat); end
        n_cmp++; if (ct !== CT_A) begin n_err++; $display("FAIL spur_round3_ct: got %h want %h", ct, CT_A); end
        @(negedge clk_in);
    endtask

    initial begin
        rst_n_in      = 1'b0;
        req_valid_in  = 1'b0;
        req_data_in   = '0;
        req_key_in    = '0;
        resp_ready_in = 1'b1;
        spur_valid    = 1'b0;
        spur_data     = '0;
        key10_seen    = '0;
        build_sbox();
        repeat (3) @(negedge clk_in);
        rst_n_in = 1'b1;
        @(negedge clk_in);
        test_reset();
        test_fips_c1();
        test_round_trace();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_spurious();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/aes_round_controller.md
AES_ROUND_CONTROLLER -- requirements
Module: aes_round_controller

Interface
REQ-001 SHALL have no parameters.
REQ-002 clk_in  input  1  single clock; all state on rising edge.
REQ-003 rst_n_in  input  1  reset, asynchronous assert, active-low.
REQ-004 req_valid_in  input  1  encryption request valid.
REQ-005 req_ready_out  output  1  controller can accept request.
REQ-006 req_data_in  input  128  plaintext, FIPS-197 byte order (byte 0 = [127:120]).
REQ-007 req_key_in  input  128  AES-128 cipher key, FIPS-197 byte order.
REQ-008 resp_valid_out  output  1  ciphertext valid.
REQ-009 resp_ready_in  input  1  consumer accepts ciphertext.
REQ-010 resp_data_out  output  128  ciphertext, FIPS-197 byte order.
REQ-011 eng_init_out  output  1  start pulse to round engine.
REQ-012 eng_data_out  output  128  plaintext to engine, engine layout.
REQ-013 eng_round_out  output  4  current round (0..10) to engine.
REQ-014 eng_key_out  output  128  current round key, engine layout.
REQ-015 eng_next_round_in  input  1  engine one-cycle pulse after each AddRoundKey.
REQ-016 eng_data_in  input  128  engine state, engine layout.
REQ-017 eng_valid_in  input  1  engine one-cycle done pulse.

Function
REQ-018 Layout: engine byte 4*r+c SHALL equal FIPS byte 4*c+r; applied to eng_data_out, eng_key_out, and inversely to captured eng_data_in.
REQ-019 States SHALL be IDLE, INIT, ROUND0, RUN, RESP.
REQ-020 req_ready_out SHALL be 1 only in IDLE; accept = req_valid_in & req_ready_out -> latch data/key, go INIT.
REQ-021 INIT (1 cycle): eng_init_out=1, eng_round_out=0, eng_key_out=K0; next state ROUND0.
REQ-022 ROUND0 (1 cycle, unconditional): eng_round_out=0, eng_key_out=K0; at its end round<=1, key<=K1, state RUN, skip flag set.
REQ-023 RUN: first cycle with eng_next_round_in=1 SHALL only clear skip flag; each later such cycle with round<10 SHALL increment round and update key to K(round+1) on the same edge.
REQ-024 Key schedule SHALL be on-the-fly AES-128 (RotWord, SubWord, Rcon 01,02,04,08,10,20,40,80,1b,36 for rounds 1..10); one key step per round advance.
REQ-025 eng_next_round_in SHALL be ignored when round=10 and outside RUN.
REQ-026 eng_valid_in in RUN with round=10 SHALL capture eng_data_in (de-transposed) into resp_data_out and go RESP; eng_valid_in elsewhere SHALL be ignored.
REQ-027 RESP: resp_valid_out=1, resp_data_out stable until resp_valid_out & resp_ready_in; then IDLE (req_ready_out=1 the next cycle, no same-cycle re-accept).
REQ-028 Latency: resp_valid_out SHALL rise 42 cycles after the accepting edge with the standard engine (round 1..9: 4 cycles, round 10: 3 cycles).
REQ-029 eng_round_out and eng_key_out SHALL be registered and never change except at REQ-022/REQ-023 edges or return to IDLE.
REQ-030 In IDLE eng_round_out=0, eng_init_out=0.

Reset
REQ-031 rst_n_in=0 SHALL immediately force IDLE, req_ready_out=1 after release, resp_valid_out=0, eng_init_out=0, eng_round_out=0, eng_key_out=0, eng_data_out=0, resp_data_out=0, skip flag clear.
REQ-032 Reset mid-operation SHALL discard the in-flight block; no response is produced.

Verification
REQ-033 FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> resp_data_out 69c4e0d86a7b0430d8cdb78070b4c55a, 42 cycles after accept.
REQ-034 Round trace: same request -> eng_round_out 0,0,1..10; K10 (FIPS order) = 13111d7fe3944a17f307a78b4d2b30c5; round-0 next_round pulse not counted.
REQ-035 Backpressure: resp_ready_in=0 for 20 cycles -> resp_valid_out held, data stable; req_ready_out=0 throughout; accept on release.
REQ-036 Back-to-back: two requests with req_valid_in held high -> second accepted the cycle after IDLE re-entry, both ciphertexts correct.
REQ-037 Reset at round 5 -> all outputs to reset values asynchronously; next request yields correct ciphertext.
REQ-038 Spurious eng_valid_in forced in IDLE and at round 3 -> ignored; no resp_valid_out.
